// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs a single-outstanding imem handshake,
// holds each fetched word until decode accepts it and applies execute redirects.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        id_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget
);

    localparam logic [31:0] ResetPcAligned = RESET_PC & 32'hFFFF_FFFC;
    localparam logic [31:0] NopInstr       = 32'h0000_0013;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] target;

    assign target = PCTarget & 32'hFFFF_FFFC;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            pc_q       <= ResetPcAligned;
            kill_q     <= 1'b0;
            instr_q    <= NopInstr;
            instr_pc_q <= ResetPcAligned;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;

        unique case (state_q)
            StIdle: begin
                state_d = StReq;
                pc_d    = PCSrc ? target : ResetPcAligned;
            end
            StReq: begin
                if (PCSrc) begin
                    pc_d = target;
                end
                if (imem_ready) begin
                    state_d = StWait;
                    // Accepted request is for the old PC; its response must be discarded.
                    kill_d  = PCSrc;
                end
            end
            StWait: begin
                if (PCSrc) begin
                    pc_d   = target;
                    kill_d = 1'b1;
                end
                if (imem_rvalid) begin
                    if (kill_q || PCSrc) begin
                        kill_d  = 1'b0;
                        state_d = StReq;
                    end else begin
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                        state_d    = StHold;
                    end
                end
            end
            StHold: begin
                if (PCSrc) begin
                    pc_d    = target;
                    state_d = StReq;
                end else if (id_ready) begin
                    pc_d    = instr_pc_q + 32'd4;
                    state_d = StReq;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // All handshake outputs decode directly from flops.
    assign imem_req    = (state_q == StReq);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == StHold);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pc_plus4    = instr_pc_q + 32'd4;
    assign op          = instr_q[6:0];
    assign funct3      = instr_q[14:12];
    assign funct7      = instr_q[30];

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Sequential instruction fetch stage that supplies instructions to the control unit and datapath decode. It owns the program counter and runs a single-outstanding request/response handshake with instruction memory. It holds each fetched word in an instruction register until decode accepts it, and applies branch/jump redirects (`PCSrc`/`PCTarget`) from execute, discarding any wrong-path fetch in flight.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC of the first fetch after reset (word-aligned).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch address; bits [1:0] always 0.
- `imem_ready`  in  1  memory accepts request this cycle (`imem_req && imem_ready`).
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  32  instruction word.
- `instr_valid`  out  1  instruction register holds a valid instruction.
- `id_ready`  in  1  decode accepts the held instruction (`instr_valid && id_ready`).
- `instr`  out  32  held instruction word.
- `instr_pc`  out  32  PC of the held instruction.
- `pc_plus4`  out  32  `instr_pc + 4`, modulo 2^32.
- `op`  out  7  `instr[6:0]`.
- `funct3`  out  3  `instr[14:12]`.
- `funct7`  out  1  `instr[30]` (funct7 bit 5).
- `PCSrc`  in  1  redirect request from execute.
- `PCTarget`  in  32  redirect target; bits [1:0] ignored and forced to 0.

## Operation
- Four states: IDLE, REQ, WAIT, HOLD. At most one memory request is outstanding.
- **IDLE**: entered on reset. Lasts one cycle, then goes to REQ with `pc = RESET_PC`.
- **REQ**: `imem_req = 1`, `imem_addr = pc`.
  - On `imem_ready`: go to WAIT.
  - Otherwise: stay in REQ with the address stable, unless a redirect arrives.
- **WAIT**: `imem_req = 0`.
  - On `imem_rvalid`: capture `imem_rdata` into `instr`, `pc` into `instr_pc`, then go to HOLD.
- **HOLD**: `instr_valid = 1`.
  - On `id_ready`: go to REQ with `pc = instr_pc + 4`. `instr_valid` falls next cycle.
- **Redirect** (`PCSrc = 1`, sampled in every state): `pc <= {PCTarget[31:2], 2'b00}`. Per-state behaviour:
  - IDLE: next state is REQ at the target.
  - REQ, not accepted this cycle: request withdrawn. `imem_addr` shows the target next cycle; stay in REQ.
  - REQ, accepted this cycle: go to WAIT with the `kill` flag set.
  - WAIT: set `kill`. The next `imem_rvalid` is dropped (no capture), `kill` clears, then go to REQ at the target.
  - HOLD: held instruction dropped; `instr_valid` = 0 next cycle; go to REQ at the target. Redirect wins over a same-cycle `id_ready`; the fetch address is the target, not `instr_pc + 4`.
- `kill` and `imem_rvalid` in the same cycle as a new `PCSrc`: the response is dropped and `pc` takes the newest target.
- `op`/`funct3`/`funct7` are pure slices of `instr`. They change only when `instr` is captured.
- PC arithmetic is 32-bit and wraps: `32'hFFFF_FFFC + 4 = 0`.

## Timing
- Reset values (asserted asynchronously):
  - `imem_req = 0`, `imem_addr = RESET_PC`, `instr_valid = 0`.
  - `instr = 32'h0000_0013` (NOP); `op = 7'h13`, `funct3 = 0`, `funct7 = 0`.
  - `instr_pc = RESET_PC`, `pc_plus4 = RESET_PC + 4`, `kill = 0`, state IDLE.
- Reset deassert at edge 0: `imem_req` rises after edge 1.
- Zero-wait memory (`imem_ready = 1`, `imem_rvalid` one cycle after acceptance), `id_ready = 1`: REQ→WAIT→HOLD, one instruction every 3 cycles. `instr_valid` rises 2 cycles after the request is accepted.
- Handshake-driven outputs (`imem_req`, `imem_addr`, `instr_valid`) are registered: no combinational path from any input to them.
- `imem_rvalid` outside WAIT is ignored.
- Reset mid-operation: immediate return to reset values. The memory is reset by the same `rst`.

## Test plan
- **Reset/first fetch**: `RESET_PC = 32'h100`, release `rst`.
  - `imem_req = 1`, `imem_addr = 32'h100` after edge 1.
  - Return `32'h0020_8033` → `instr_valid = 1`, `op = 7'h33`, `funct3 = 0`, `funct7 = 0`, `instr_pc = 32'h100`.
- **Sequential stream**: zero-wait memory, `id_ready = 1`, 4 instructions.
  - Addresses `0x100, 0x104, 0x108, 0x10C`, one `instr_valid` pulse every 3 cycles.
- **Backpressure**: `imem_ready = 0` for 3 cycles → `imem_addr` stable.
  - `id_ready = 0` for 5 cycles in HOLD → `instr`/`instr_valid` stable, no new request.
- **Redirect in WAIT**: `PCSrc = 1`, `PCTarget = 32'h203` while waiting.
  - Response `32'hDEAD_BEEF` dropped, `instr_valid` stays 0.
  - Next request `imem_addr = 32'h200`.
- **Redirect in HOLD with same-cycle `id_ready`**: `PCTarget = 32'h40`.
  - `instr_valid = 0` next cycle; next `imem_addr = 32'h40`, not `instr_pc + 4`.
- **Wrap and async reset**:
  - Fetch at `32'hFFFF_FFFC`, accept → next address `0`.
  - Pull `rst` low mid-WAIT → outputs at reset values before the next clock edge.
